// File: rtl/image_filter_pkg.sv
// Shared types, kernels and arithmetic constants for the pipelined 3x3 image filter.
package image_filter_pkg;

    typedef enum logic [2:0] {
        FILT_LAP4  = 3'd0,
        FILT_LAP8  = 3'd1,
        FILT_GAUSS = 3'd2,
        FILT_AVG   = 3'd3,
        FILT_PROG  = 3'd4
    } filt_mode_e;

    localparam int KERNEL_TAPS = 9;
    localparam int CENTRE_TAP  = 4;

    // Row-major kernels, tap 4 is the centre.
    localparam int K_LAP4  [KERNEL_TAPS] = '{ 0, -1,  0, -1, 4, -1,  0, -1,  0};
    localparam int K_LAP8  [KERNEL_TAPS] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    localparam int K_GAUSS [KERNEL_TAPS] = '{ 1,  2,  1,  2, 4,  2,  1,  2,  1};
    localparam int K_AVG   [KERNEL_TAPS] = '{ 1,  1,  1,  1, 1,  1,  1,  1,  1};

    // Division by nine approximated as *57/512.
    localparam int AVG_MUL   = 57;
    localparam int AVG_SHIFT = 9;

    // Signed product (data+1 sign bit+coef) plus four bits of growth for nine terms.
    function automatic int acc_width(input int data_bw, input int coef_bw);
        return data_bw + coef_bw + 5;
    endfunction

    // Codes above FILT_PROG alias the averaging kernel.
    function automatic filt_mode_e decode_mode(input logic [2:0] cfg);
        case (cfg)
            3'd0:    return FILT_LAP4;
            3'd1:    return FILT_LAP8;
            3'd2:    return FILT_GAUSS;
            3'd4:    return FILT_PROG;
            default: return FILT_AVG;
        endcase
    endfunction

    function automatic int builtin_coef(input filt_mode_e mode, input int tap);
        case (mode)
            FILT_LAP4:  return K_LAP4[tap];
            FILT_LAP8:  return K_LAP8[tap];
            FILT_GAUSS: return K_GAUSS[tap];
            default:    return K_AVG[tap];
        endcase
    endfunction

endpackage

// File: rtl/image_filter_adder_tree.sv
// Registered signed reduction of the per-tap products into one accumulator (stage S2).
module image_filter_adder_tree #(
    parameter int p_in_bw  = 16,
    parameter int p_out_bw = 20,
    parameter int p_taps   = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [p_taps*p_in_bw-1:0]  terms,
    output logic signed [p_out_bw-1:0] sum
);

    logic signed [p_out_bw-1:0] sum_next;

    // NOTE: blocking '=' inside always_comb lets each loop pass see the previous partial sum.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < p_taps; i++) begin
            sum_next = sum_next + p_out_bw'($signed(terms[i*p_in_bw +: p_in_bw]));
        end
    end

    // NOTE: state uses '<=' so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/image_filter_pipe.sv
// Three-stage 3x3 convolution filter with valid/ready flow control, a programmable
// kernel bank and a saturation counter.
module image_filter_pipe
    import image_filter_pkg::*;
#(
    parameter int p_data_bw  = 10,
    parameter int p_win_size = 9,
    parameter int p_coef_bw  = 5,
    parameter int p_cnt_bw   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [2:0]                        i_config,
    input  logic [3:0]                        i_prog_shift,
    input  logic                              i_coef_we,
    input  logic [3:0]                        i_coef_addr,
    input  logic [p_coef_bw-1:0]              i_coef_data,
    input  logic                              i_cnt_clr,
    input  logic                              i_dxi_in_valid,
    output logic                              o_dxi_in_ready,
    input  logic [p_data_bw*p_win_size-1:0]   i_dxi_in_data,
    output logic [p_data_bw-1:0]              o_dxi_out_data,
    output logic                              o_dxi_out_valid,
    input  logic                              i_dxi_out_ready,
    output logic [p_cnt_bw-1:0]               o_sat_cnt
);

    localparam int PROD_BW = p_data_bw + p_coef_bw + 1;
    localparam int ACC_BW  = acc_width(p_data_bw, p_coef_bw);
    localparam int NORM_BW = ACC_BW + 7;
    localparam logic [p_data_bw-1:0] PIX_MAX = '1;

    if (p_win_size != KERNEL_TAPS) begin : g_bad_win_size
        $error("image_filter_pipe supports only a 3x3 window (p_win_size = 9)");
    end

    logic                        en;
    filt_mode_e                  in_mode;
    logic signed [p_coef_bw-1:0] coef_bank [p_win_size];
    logic signed [p_coef_bw-1:0] kernel    [p_win_size];
    logic [p_win_size*PROD_BW-1:0] prod_next;

    logic                          s1_valid;
    filt_mode_e                    s1_mode;
    logic [3:0]                    s1_shift;
    logic [p_win_size*PROD_BW-1:0] s1_prod;

    logic                          s2_valid;
    filt_mode_e                    s2_mode;
    logic [3:0]                    s2_shift;
    logic signed [ACC_BW-1:0]      s2_acc;

    logic [ACC_BW-1:0]             mag;
    logic [NORM_BW-1:0]            norm;
    logic                          sat_next;
    logic [p_data_bw-1:0]          pix_next;
    logic                          out_sat;

    // Every stage moves together; a held output freezes the whole pipe, bubbles included.
    assign en             = !o_dxi_out_valid || i_dxi_out_ready;
    assign o_dxi_in_ready = en;

    // NOTE: the bank is reset because reset must restore the identity kernel, unlike a plain data RAM.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < p_win_size; i++) begin
                coef_bank[i] <= (i == CENTRE_TAP) ? p_coef_bw'(1) : '0;
            end
        end else if (i_coef_we && (int'(i_coef_addr) < p_win_size)) begin
            coef_bank[i_coef_addr] <= i_coef_data;
        end
    end

    always_comb begin
        in_mode   = decode_mode(i_config);
        prod_next = '0;
        for (int i = 0; i < p_win_size; i++) begin
            kernel[i] = (in_mode == FILT_PROG) ? coef_bank[i]
                                               : p_coef_bw'(builtin_coef(in_mode, i));
            prod_next[i*PROD_BW +: PROD_BW] =
                PROD_BW'($signed({1'b0, i_dxi_in_data[i*p_data_bw +: p_data_bw]})) *
                PROD_BW'(kernel[i]);
        end
    end

    // S1: mode, shift and kernel are latched with the sample so later changes never reach it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_mode  <= FILT_LAP4;
            s1_shift <= '0;
            s1_prod  <= '0;
        end else if (en) begin
            s1_valid <= i_dxi_in_valid;
            s1_mode  <= in_mode;
            s1_shift <= i_prog_shift;
            s1_prod  <= prod_next;
        end
    end

    image_filter_adder_tree #(
        .p_in_bw  (PROD_BW),
        .p_out_bw (ACC_BW),
        .p_taps   (p_win_size)
    ) u_adder_tree (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .en    (en),
        .terms (s1_prod),
        .sum   (s2_acc)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_valid <= 1'b0;
            s2_mode  <= FILT_LAP4;
            s2_shift <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_shift <= s1_shift;
        end
    end

    // Built-in smoothing kernels never go negative, so taking |acc| first is safe for every mode.
    // NOTE: every comb output gets a value before the case so no path can infer a latch.
    always_comb begin
        mag  = s2_acc[ACC_BW-1] ? -s2_acc : s2_acc;
        norm = NORM_BW'(mag);
        case (s2_mode)
            FILT_LAP4:  norm = norm >> 2;
            FILT_LAP8:  norm = norm >> 3;
            FILT_GAUSS: norm = norm >> 4;
            FILT_AVG:   norm = (norm * NORM_BW'(AVG_MUL)) >> AVG_SHIFT;
            FILT_PROG:  norm = norm >> s2_shift;
            default:    norm = norm;
        endcase
        sat_next = norm > NORM_BW'(PIX_MAX);
        pix_next = sat_next ? PIX_MAX : norm[p_data_bw-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_dxi_out_valid <= 1'b0;
            o_dxi_out_data  <= '0;
            out_sat         <= 1'b0;
        end else if (en) begin
            o_dxi_out_valid <= s2_valid;
            if (s2_valid) begin
                o_dxi_out_data <= pix_next;
                out_sat        <= sat_next;
            end
        end
    end

    // Counts clamped pixels as they leave; clear has priority and the count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sat_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_sat_cnt <= '0;
        end else if (o_dxi_out_valid && i_dxi_out_ready && out_sat && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_image_filter_pipe.sv
// Randomised scoreboard bench for image_filter_pipe against an integer reference model.
module tb_image_filter_pipe;

    typedef struct {
        int pix;
        bit sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cfg;
    logic [3:0]  prog_shift;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [4:0]  coef_data;
    logic        cnt_clr;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sat_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   bank[9];
    int   exp_cnt = 0;
    bit   rand_ready = 0;

    image_filter_pipe dut (
        .i_clk           (clk),
        .i_rstn          (rst_n),
        .i_config        (cfg),
        .i_prog_shift    (prog_shift),
        .i_coef_we       (coef_we),
        .i_coef_addr     (coef_addr),
        .i_coef_data     (coef_data),
        .i_cnt_clr       (cnt_clr),
        .i_dxi_in_valid  (in_valid),
        .o_dxi_in_ready  (in_ready),
        .i_dxi_in_data   (in_data),
        .o_dxi_out_data  (out_data),
        .o_dxi_out_valid (out_valid),
        .i_dxi_out_ready (out_ready),
        .o_sat_cnt       (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bank_identity();
        for (int i = 0; i < 9; i++) bank[i] = (i == 4) ? 1 : 0;
    endtask

    // Reference filter: integer convolution, abs, divide, clamp.
    function automatic exp_t model(input int win[9], input int c, input int shift);
        exp_t   e;
        int     k[9];
        int     mode;
        longint acc;
        longint mag;
        longint r;
        mode = (c > 4) ? 3 : c;
        acc  = 0;
        for (int i = 0; i < 9; i++) begin
            case (mode)
                0:       k[i] = (i == 4) ? 4 : ((i % 2 == 1) ? -1 : 0);
                1:       k[i] = (i == 4) ? 8 : -1;
                2:       k[i] = (i == 4) ? 4 : ((i % 2 == 1) ? 2 : 1);
                3:       k[i] = 1;
                default: k[i] = bank[i];
            endcase
            acc += longint'(win[i]) * k[i];
        end
        mag = (acc < 0) ? -acc : acc;
        case (mode)
            0:       r = mag / 4;
            1:       r = mag / 8;
            2:       r = acc / 16;
            3:       r = (acc * 57) / 512;
            default: r = mag / (longint'(1) << shift);
        endcase
        e.sat = (r > 1023);
        e.pix = e.sat ? 1023 : int'(r);
        return e;
    endfunction

    task automatic send(input int win[9], input int c, input int shift,
                        input bit we = 0, input int waddr = 0, input int wdata = 0);
        int budget;
        bit done;
        for (int i = 0; i < 9; i++) in_data[i*10 +: 10] = 10'(win[i]);
        cfg        = 3'(c);
        prog_shift = 4'(shift);
        in_valid   = 1'b1;
        coef_we    = we;
        coef_addr  = 4'(waddr);
        coef_data  = 5'(wdata);
        budget     = 0;
        done       = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(win, c, shift));
                done = 1;
            end
            @(posedge clk);
            #1;
            if (coef_we) begin
                if (waddr < 9) bank[waddr] = wdata;
                coef_we = 1'b0;
            end
            budget++;
            if (!done && budget > 200) begin
                check("accept_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int waddr, input int wdata);
        coef_we   = 1'b1;
        coef_addr = 4'(waddr);
        coef_data = 5'(wdata);
        @(posedge clk);
        #1;
        if (waddr < 9) bank[waddr] = wdata;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops on each output handshake, checks held data during stalls, tracks the counter.
    always @(negedge clk) begin
        exp_t e;
        bit   sat_seen;
        sat_seen = 0;
        if (!rst_n) begin
            exp_cnt = 0;
        end else begin
            if (out_valid && !out_ready) begin
                check("in_ready_stall", in_ready, 0);
                if (sb.size() > 0) check("stall_hold", out_data, sb[0].pix);
            end
            if (out_valid && out_ready) begin
                check("sat_cnt", sat_cnt, exp_cnt);
                check("output_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.pix);
                    sat_seen = e.sat;
                end
            end
            if (cnt_clr) exp_cnt = 0;
            else if (out_valid && out_ready && sat_seen && exp_cnt < 65535) exp_cnt++;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        check("watchdog", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int win[9];
        int lat;
        rst_n = 1'b0; cfg = '0; prog_shift = '0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; cnt_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        bank_identity();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Gaussian flat field and three-edge latency.
        for (int i = 0; i < 9; i++) win[i] = 100;
        send(win, 2, 0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_edges", lat, 3);
        drain();

        // Laplacians on a cross of maximal neighbours.
        for (int i = 0; i < 9; i++) win[i] = (i % 2 == 1) ? 1023 : 0;
        send(win, 0, 0);
        send(win, 1, 0);
        drain();
        check("sat_cnt_no_sat", sat_cnt, 0);

        // Averaging saturation, then a clear on the next saturating handshake (alias code 101).
        for (int i = 0; i < 9; i++) win[i] = 1023;
        send(win, 3, 0);
        drain();
        check("sat_cnt_after_avg", sat_cnt, 1);
        send(win, 5, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        drain();
        check("sat_cnt_after_clr", sat_cnt, 0);

        // Continuous stream of 8 distinct windows with a 5-cycle downstream stall.
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    int w[9];
                    for (int i = 0; i < 9; i++) w[i] = (n * 97 + i * 13 + int'($urandom_range(0, 40))) % 1024;
                    send(w, n % 4, 0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Programmable kernel, including a write on the same edge as an acceptance.
        write_coef(4, 2);
        for (int i = 0; i < 9; i++) win[i] = (i == 4) ? 500 : 0;
        send(win, 4, 1);
        send(win, 4, 1, 1, 4, -3);
        send(win, 4, 1);
        drain();

        // Randomised traffic, modes, shifts, coefficient writes and backpressure.
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0)
                send(win, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     1, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)) - 16);
            else
                send(win, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        #2 out_ready = 1'b1;
        drain();

        // Reset with three samples in flight.
        write_coef(4, 5);
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(0, 1023));
            send(win, 2, 0);
        end
        #2 rst_n = 1'b0;
        sb.delete();
        bank_identity();
        #1;
        check("midrst_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", out_valid, 0);
        for (int i = 0; i < 9; i++) win[i] = (i == 4) ? 77 : 0;
        send(win, 4, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
